// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory port (fetch = port 0, data = port 1).
// Optional round-robin tie-break: define MEM_ARB_ROUND_ROBIN_EN; default is fixed priority to port 1.
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_nx;
  logic   last_grant;
  logic   win;
  logic   load;
  logic   cap;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Winner selection, next state and load/capture strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    cap      = 1'b0;
    win      = req1_valid;
    if (req0_valid && req1_valid)
      win = RR_EN ? ~last_grant : 1'b1;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          load     = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          cap      = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side request registers, owner and per-port read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      if (load) begin
        mem_addr   <= win ? req1_addr  : req0_addr;
        mem_we     <= win ? req1_we    : req0_we;
        mem_wdata  <= win ? req1_wdata : req0_wdata;
        sel        <= win;
        last_grant <= win;
      end
      if (cap) begin
        if (sel) req1_rdata <= mem_rdata;
        else     req0_rdata <= mem_rdata;
      end
    end
  end

  assign mem_valid  = (state == BUSY);
  assign req0_ready = (state == RESP) && !sel;
  assign req1_ready = (state == RESP) &&  sel;

endmodule
